// File: rtl/fir_mc_pkg.sv
// Shared types and helpers for the multi-channel serial-MAC FIR.
// Width helpers are used to derive port and accumulator sizes from the top-level parameters.
package fir_mc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   function automatic int acc_width(input int data_w, input int coef_w, input int num_taps);
      return data_w + coef_w + $clog2(num_taps);
   endfunction

   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   function automatic int tap_width(input int num_taps);
      return (num_taps > 1) ? $clog2(num_taps) : 1;
   endfunction

   // Clamp a signed value to the range of an out_w-bit two's complement number.
   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int out_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/fir_mc_round_sat.sv
// Combinational output stage: round half toward +inf, arithmetic shift, saturate to OUT_W.
// The rounding add is carried one bit wider than the accumulator so it can never wrap.
module fir_mc_round_sat
   import fir_mc_pkg::*;
#(
   parameter int ACC_W = 18,
   parameter int SHIFT = 0,
   parameter int OUT_W = 18
) (
   input  logic signed [ACC_W-1:0] acc_i,
   output logic signed [OUT_W-1:0] res_o
);

   logic signed [ACC_W:0] ext;
   logic signed [ACC_W:0] rnd;
   logic signed [63:0]    wide;

   assign ext = {acc_i[ACC_W-1], acc_i};

   if (SHIFT > 0) begin : g_round
      localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);
      assign rnd = (ext + HALF) >>> SHIFT;
   end else begin : g_pass
      assign rnd = ext;
   end

   assign wide  = 64'(rnd);
   assign res_o = OUT_W'(sat_clamp(wide, OUT_W));

endmodule

// File: rtl/fir_mc.sv
// Time-multiplexed multi-channel FIR: one shared multiplier walks the taps of the
// addressed channel's delay line, then presents a rounded/saturated result.
//
// state   | meaning
// IDLE    | ready for a sample; coefficient writes honoured
// MAC     | one tap per cycle into the accumulator
// OUT     | result held until out_ready
module fir_mc
   import fir_mc_pkg::*;
#(
   parameter int  NUM_TAPS = 3,
   parameter int  DATA_W   = 8,
   parameter int  COEF_W   = 8,
   parameter int  NUM_CH   = 2,
   parameter int  SHIFT    = 0,
   parameter int  OUT_W    = 18,
   localparam int ACC_W    = acc_width(DATA_W, COEF_W, NUM_TAPS),
   localparam int CH_W     = ch_width(NUM_CH),
   localparam int TAP_W    = tap_width(NUM_TAPS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CH_W-1:0]          in_ch,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     coef_we,
   input  logic [TAP_W-1:0]         coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic                     coef_err,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CH_W-1:0]          out_ch,
   output logic signed [OUT_W-1:0]  out_data
);

   localparam int PROD_W = DATA_W + COEF_W;

   state_e                    state_q, state_d;
   logic signed [DATA_W-1:0]  dline_q [NUM_CH][NUM_TAPS];
   logic signed [COEF_W-1:0]  coef_q [NUM_TAPS];
   logic [CH_W-1:0]           ch_q;
   logic [TAP_W-1:0]          tap_q;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [PROD_W-1:0]  prod;
   logic signed [OUT_W-1:0]   rs_out;
   logic                      out_valid_q, coef_err_q;
   logic [CH_W-1:0]           out_ch_q;
   logic signed [OUT_W-1:0]   out_data_q;
   logic                      ch_ok, addr_ok, accept, last_tap;

   assign ch_ok    = int'({1'b0, in_ch}) < NUM_CH;
   assign addr_ok  = int'({1'b0, coef_addr}) < NUM_TAPS;
   assign in_ready = (state_q == ST_IDLE);
   assign accept   = in_valid && ch_ok && (state_q == ST_IDLE);
   assign last_tap = (tap_q == TAP_W'(NUM_TAPS - 1));

   assign prod  = PROD_W'(dline_q[ch_q][tap_q]) * PROD_W'(coef_q[tap_q]);
   assign acc_d = acc_q + ACC_W'(prod);

   // Rounds the sum including the final tap so the result registers on the last MAC edge.
   fir_mc_round_sat #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_round_sat (
      .acc_i (acc_d),
      .res_o (rs_out)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_MAC;
         ST_MAC:  if (last_tap) state_d = ST_OUT;
         ST_OUT:  if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ch_q        <= '0;
         tap_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_data_q  <= '0;
         coef_err_q  <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < NUM_TAPS; k++) dline_q[c][k] <= '0;
         end
         for (int k = 0; k < NUM_TAPS; k++) coef_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         coef_err_q <= 1'b0;
         if (coef_we) begin
            if ((state_q == ST_IDLE) && addr_ok) coef_q[coef_addr] <= coef_data;
            else coef_err_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  ch_q  <= in_ch;
                  acc_q <= '0;
                  tap_q <= '0;
                  for (int k = NUM_TAPS - 1; k > 0; k--) dline_q[in_ch][k] <= dline_q[in_ch][k-1];
                  dline_q[in_ch][0] <= in_data;
               end
            end
            ST_MAC: begin
               acc_q <= acc_d;
               tap_q <= tap_q + 1'b1;
               if (last_tap) begin
                  out_data_q  <= rs_out;
                  out_ch_q    <= ch_q;
                  out_valid_q <= 1'b1;
               end
            end
            ST_OUT: begin
               if (out_ready) out_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_data  = out_data_q;
   assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_mc.sv
// Scoreboard bench for fir_mc: three parameterisations share one stimulus bus, one is
// selected at a time; expected results come from an integer reference model.
module tb_fir_mc;

   localparam int NUM_TAPS = 3;

   typedef struct {
      int ch;
      int data;
      int acc_edge;
   } exp_t;

   logic              clk;
   logic              rst, in_valid, coef_we, out_rdy;
   logic [1:0]        in_ch, coef_addr, sel;
   logic signed [7:0] in_data, coef_data;
   logic              iv0, iv1, iv2, cw0, cw1, cw2;
   logic              ir0, ir1, ir2, ce0, ce1, ce2, ov0, ov1, ov2;
   logic              och0, och1;
   logic [1:0]        och2;
   logic signed [17:0] od0, od2;
   logic signed [7:0]  od1;
   logic              obs_ir, obs_ce, obs_ov;
   logic [1:0]        obs_och;
   logic signed [17:0] obs_od;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t sbq[$];
   exp_t mon_e;
   bit   ov_prev = 1'b0;
   int   hist[3][3][3];
   int   mcoef[3][3];
   int   msh[3] = '{0, 0, 2};
   int   mow[3] = '{18, 8, 18};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign iv0 = in_valid && (sel == 2'd0);
   assign iv1 = in_valid && (sel == 2'd1);
   assign iv2 = in_valid && (sel == 2'd2);
   assign cw0 = coef_we && (sel == 2'd0);
   assign cw1 = coef_we && (sel == 2'd1);
   assign cw2 = coef_we && (sel == 2'd2);

   fir_mc #(.NUM_TAPS(3), .DATA_W(8), .COEF_W(8), .NUM_CH(2), .SHIFT(0), .OUT_W(18)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_ch(in_ch[0]), .in_data(in_data),
      .coef_we(cw0), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(ce0),
      .out_valid(ov0), .out_ready(out_rdy), .out_ch(och0), .out_data(od0));

   fir_mc #(.NUM_TAPS(3), .DATA_W(8), .COEF_W(8), .NUM_CH(2), .SHIFT(0), .OUT_W(8)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_ch(in_ch[0]), .in_data(in_data),
      .coef_we(cw1), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(ce1),
      .out_valid(ov1), .out_ready(out_rdy), .out_ch(och1), .out_data(od1));

   fir_mc #(.NUM_TAPS(3), .DATA_W(8), .COEF_W(8), .NUM_CH(3), .SHIFT(2), .OUT_W(18)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_ch(in_ch), .in_data(in_data),
      .coef_we(cw2), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(ce2),
      .out_valid(ov2), .out_ready(out_rdy), .out_ch(och2), .out_data(od2));

   always_comb begin
      obs_ir  = ir0;
      obs_ce  = ce0;
      obs_ov  = ov0;
      obs_och = {1'b0, och0};
      obs_od  = od0;
      case (sel)
         2'd1: begin
            obs_ir  = ir1;
            obs_ce  = ce1;
            obs_ov  = ov1;
            obs_och = {1'b0, och1};
            obs_od  = {{10{od1[7]}}, od1};
         end
         2'd2: begin
            obs_ir  = ir2;
            obs_ce  = ce2;
            obs_ov  = ov2;
            obs_och = och2;
            obs_od  = od2;
         end
         default: ;
      endcase
   end

   function automatic void model_clear();
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 3; k++) begin
            mcoef[d][k] = 0;
            for (int c = 0; c < 3; c++) hist[d][c][k] = 0;
         end
      end
   endfunction

   function automatic int model_push(input int d, input int ch, input int x);
      int acc = 0;
      int hi, lo;
      for (int k = 2; k > 0; k--) hist[d][ch][k] = hist[d][ch][k-1];
      hist[d][ch][0] = x;
      for (int k = 0; k < 3; k++) acc += hist[d][ch][k] * mcoef[d][k];
      if (msh[d] > 0) acc = (acc + (1 << (msh[d] - 1))) >>> msh[d];
      hi = (1 << (mow[d] - 1)) - 1;
      lo = -hi - 1;
      if (acc > hi) acc = hi;
      else if (acc < lo) acc = lo;
      return acc;
   endfunction

   // Compare each result as it is handed off, and its arrival time against its accept edge.
   always @(negedge clk) begin
      if (obs_ov === 1'b1 && !ov_prev) begin
         checks++;
         if (sbq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output got ch=%0d data=%0d required no output", obs_och, obs_od);
         end else if (cyc - sbq[0].acc_edge + 1 != NUM_TAPS + 1) begin
            failures++;
            $display("FAIL latency got %0d edges required %0d", cyc - sbq[0].acc_edge + 1, NUM_TAPS + 1);
         end
      end
      if (obs_ov === 1'b1 && out_rdy === 1'b1 && sbq.size() != 0) begin
         mon_e = sbq.pop_front();
         checks++;
         if (int'(obs_od) !== mon_e.data || int'(obs_och) !== mon_e.ch) begin
            failures++;
            $display("FAIL result got ch=%0d data=%0d required ch=%0d data=%0d",
                     obs_och, obs_od, mon_e.ch, mon_e.data);
         end
      end
      ov_prev = (obs_ov === 1'b1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int ch, input int d, output int acc_edge);
      int n = 0;
      in_ch    = 2'(ch);
      in_data  = 8'(d);
      in_valid = 1'b1;
      while (obs_ir !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (obs_ir !== 1'b1) begin
         failures++;
         $display("FAIL send_timeout got in_ready=%b required 1", obs_ir);
         in_valid = 1'b0;
         acc_edge = -1;
         return;
      end
      acc_edge = cyc + 1;
      sbq.push_back('{ch, model_push(int'(sel), ch, d), acc_edge});
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send1(input int ch, input int d);
      int e;
      send(ch, d, e);
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout got %0d pending required 0", sbq.size());
         sbq.delete();
      end
      tick();
   endtask

   task automatic set_coef(input int a, input int v, input bit exp_err);
      coef_addr = 2'(a);
      coef_data = 8'(v);
      coef_we   = 1'b1;
      tick();
      coef_we = 1'b0;
      checks++;
      if (obs_ce !== exp_err) begin
         failures++;
         $display("FAIL coef_err got %b required %b (addr %0d)", obs_ce, exp_err, a);
      end
      if (!exp_err) mcoef[int'(sel)][a] = v;
      tick();
      checks++;
      if (obs_ce !== 1'b0) begin
         failures++;
         $display("FAIL coef_err_pulse got %b required 0", obs_ce);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         #1;
         checks++;
         if (obs_ov !== 1'b0 || obs_od !== 18'sd0 || obs_och !== 2'd0 || obs_ce !== 1'b0) begin
            failures++;
            $display("FAIL reset_state dut%0d got ov=%b od=%0d och=%0d ce=%b required all 0",
                     k, obs_ov, obs_od, obs_och, obs_ce);
         end
      end
      rst = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         #1;
         checks++;
         if (obs_ir !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready dut%0d got %b required 1", k, obs_ir);
         end
      end
      sel = 2'd0;
      model_clear();
      tick();
   endtask

   task automatic test_impulse();
      sel = 2'd0;
      out_rdy = 1'b1;
      set_coef(0, 2, 1'b0);
      set_coef(1, 4, 1'b0);
      set_coef(2, 6, 1'b0);
      send1(0, 1);
      send1(0, 0);
      send1(0, 0);
      send1(0, 0);
      drain();
   endtask

   task automatic test_isolation();
      for (int i = 0; i < 3; i++) begin
         send1(0, (i == 0) ? 1 : 0);
         send1(1, 10);
      end
      drain();
   endtask

   task automatic test_saturation();
      sel = 2'd1;
      for (int k = 0; k < 3; k++) set_coef(k, 127, 1'b0);
      for (int i = 0; i < 3; i++) send1(0, 127);
      for (int i = 0; i < 3; i++) send1(1, -128);
      drain();
   endtask

   task automatic test_rounding();
      int vals[5] = '{6, -6, 5, 2, -2};
      sel = 2'd2;
      set_coef(0, 1, 1'b0);
      for (int i = 0; i < 5; i++) send1(0, vals[i]);
      send1(2, 6);
      drain();
   endtask

   task automatic test_backpressure();
      int n = 0;
      logic signed [17:0] d0;
      logic [1:0] c0;
      sel = 2'd0;
      out_rdy = 1'b0;
      send1(1, 3);
      while (obs_ov !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (obs_ov !== 1'b1) begin
         failures++;
         $display("FAIL bp_valid_timeout got %b required 1", obs_ov);
      end
      d0 = obs_od;
      c0 = obs_och;
      in_ch    = 2'd0;
      in_data  = 8'sd77;
      in_valid = 1'b1;
      repeat (5) begin
         tick();
         checks++;
         if (obs_od !== d0 || obs_och !== c0 || obs_ir !== 1'b0 || obs_ov !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold got od=%0d och=%0d ir=%b ov=%b required od=%0d och=%0d ir=0 ov=1",
                     obs_od, obs_och, obs_ir, obs_ov, d0, c0);
         end
      end
      in_valid = 1'b0;
      out_rdy  = 1'b1;
      tick();
      checks++;
      if (obs_ir !== 1'b1 || obs_ov !== 1'b0) begin
         failures++;
         $display("FAIL bp_release got ir=%b ov=%b required ir=1 ov=0", obs_ir, obs_ov);
      end
      send1(0, 1);
      drain();
   endtask

   task automatic test_illegal();
      sel = 2'd0;
      set_coef(3, 50, 1'b1);
      send1(0, 1);
      set_coef(0, 99, 1'b1);
      drain();
      sel = 2'd2;
      in_ch    = 2'd3;
      in_data  = 8'sd9;
      in_valid = 1'b1;
      repeat (4) begin
         tick();
         checks++;
         if (obs_ir !== 1'b1 || obs_ov !== 1'b0) begin
            failures++;
            $display("FAIL bad_channel got ir=%b ov=%b required ir=1 ov=0", obs_ir, obs_ov);
         end
      end
      in_valid = 1'b0;
      send1(0, 7);
      drain();
   endtask

   task automatic test_back_to_back();
      int e[4];
      sel = 2'd0;
      out_rdy = 1'b1;
      for (int i = 0; i < 4; i++) send(i % 2, i + 1, e[i]);
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (e[i] - e[i-1] != NUM_TAPS + 2) begin
            failures++;
            $display("FAIL throughput got %0d cycles required %0d", e[i] - e[i-1], NUM_TAPS + 2);
         end
      end
      drain();
   endtask

   task automatic test_mid_reset();
      sel = 2'd0;
      send1(0, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(sbq.pop_back());
      model_clear();
      checks++;
      if (obs_ov !== 1'b0 || obs_ir !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset got ov=%b ir=%b required ov=0 ir=1", obs_ov, obs_ir);
      end
      repeat (6) begin
         tick();
         checks++;
         if (obs_ov !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_no_output got ov=%b required 0", obs_ov);
         end
      end
      send1(0, 1);
      send1(0, 0);
      send1(0, 0);
      drain();
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      coef_we = 1'b0;
      out_rdy = 1'b1;
      in_ch = 2'd0;
      coef_addr = 2'd0;
      in_data = 8'sd0;
      coef_data = 8'sd0;
      sel = 2'd0;
      model_clear();
      test_reset();
      test_impulse();
      test_isolation();
      test_saturation();
      test_rounding();
      test_backpressure();
      test_illegal();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired required completion");
      $fatal(1);
   end

endmodule
